// File: rtl/mips32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mips32_mem_arbiter
//
// Shares one single-ported 1024x32 unified memory between the instruction-fetch
// stage (IF port, read-only) and the memory-access stage (DM port, read/write).
// Only one access is in flight at a time. Each access holds the memory for
// MEM_LAT cycles. The winner then receives its data or write acknowledge.
//
// Ports
//   clk1, rst_n                     clock (rising edge), async active-low reset
//   if_req/if_addr                  IF read request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata       IF accept pulse, data-valid pulse, read data
//   flush                           discard the in-flight IF result
//   dm_req/dm_we/dm_addr/dm_wdata   DM request, held until dm_gnt
//   dm_gnt/dm_rvalid/dm_rdata       DM accept pulse, done pulse, read data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata             memory array interface
//   busy                            an access is in flight
//
// Configuration macro
//   ARB_RR_EN  defined   : when both ports request together, round-robin picks
//                          the port that did not win the previous grant
//   ARB_RR_EN  undefined : fixed priority, DM beats IF
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module mips32_mem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              flush,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Port encoding shared by owner and last-winner bookkeeping
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Wide enough for the legal latency range 1..4
  localparam int             CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = 3'd1;
  localparam logic [CNT_W-1:0] CNT_ZERO = 3'd0;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                owner_r;
  logic                acc_we_r;
  logic                drop_if_r;

  logic                if_gnt_r;
  logic                if_rvalid_r;
  logic [DATA_W-1:0]   if_rdata_r;
  logic                dm_gnt_r;
  logic                dm_rvalid_r;
  logic [DATA_W-1:0]   dm_rdata_r;
  logic                mem_en_r;
  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic                busy_r;

  logic                any_req_s;
  logic                pick_dm_s;
  logic                grant_s;

  assign any_req_s = if_req | dm_req;
  // A grant can only be issued from IDLE; requests are ignored in WAIT
  assign grant_s   = (state_r == ST_IDLE) & any_req_s;

`ifdef ARB_RR_EN
  logic last_winner_r;

  // Remember which port took the most recent grant, used to break ties
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      last_winner_r <= OWN_DM;
    end else if (grant_s) begin
      last_winner_r <= pick_dm_s;
    end else begin
      last_winner_r <= last_winner_r;
    end
  end
`endif

  // Choose the winner among the ports requesting this cycle
  always_comb begin
    pick_dm_s = OWN_IF;
    if (dm_req && if_req) begin
`ifdef ARB_RR_EN
      // On a tie the port that did not win last time goes next
      pick_dm_s = (last_winner_r == OWN_IF) ? OWN_DM : OWN_IF;
`else
      pick_dm_s = OWN_DM;
`endif
    end else if (dm_req) begin
      pick_dm_s = OWN_DM;
    end else begin
      pick_dm_s = OWN_IF;
    end
  end

  // Access sequencer: grant in IDLE, count down the memory latency in WAIT
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      owner_r     <= OWN_IF;
      acc_we_r    <= 1'b0;
      drop_if_r   <= 1'b0;
      if_gnt_r    <= 1'b0;
      if_rvalid_r <= 1'b0;
      if_rdata_r  <= {DATA_W{1'b0}};
      dm_gnt_r    <= 1'b0;
      dm_rvalid_r <= 1'b0;
      dm_rdata_r  <= {DATA_W{1'b0}};
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      // Strobes and pulses are single-cycle unless re-asserted below
      if_gnt_r    <= 1'b0;
      dm_gnt_r    <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      if_rvalid_r <= 1'b0;
      dm_rvalid_r <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            owner_r    <= pick_dm_s;
            acc_we_r   <= pick_dm_s & dm_we;
            if_gnt_r   <= ~pick_dm_s;
            dm_gnt_r   <= pick_dm_s;
            mem_en_r   <= 1'b1;
            mem_we_r   <= pick_dm_s & dm_we;
            mem_addr_r <= pick_dm_s ? dm_addr : if_addr;
            // IF never writes, so write data is only refreshed for DM
            mem_wdata_r <= pick_dm_s ? dm_wdata : mem_wdata_r;
            cnt_r      <= CNT_LOAD;
            busy_r     <= 1'b1;
            drop_if_r  <= 1'b0;
            state_r    <= ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_WAIT: begin
          // A taken branch makes the pending fetch useless
          if (flush && (owner_r == OWN_IF)) begin
            drop_if_r <= 1'b1;
          end else begin
            drop_if_r <= drop_if_r;
          end

          if (cnt_r <= CNT_ONE) begin
            // Memory data is valid on this edge: hand it to the owner
            cnt_r     <= CNT_ZERO;
            busy_r    <= 1'b0;
            drop_if_r <= 1'b0;
            state_r   <= ST_IDLE;
            if (owner_r == OWN_DM) begin
              dm_rvalid_r <= 1'b1;
              if (!acc_we_r) begin
                dm_rdata_r <= mem_rdata;
              end else begin
                dm_rdata_r <= dm_rdata_r;
              end
            end else if (!(drop_if_r || flush)) begin
              if_rvalid_r <= 1'b1;
              if_rdata_r  <= mem_rdata;
            end else begin
              if_rdata_r <= if_rdata_r;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        default: begin
          // Unreachable encoding: return to a safe idle state
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt    = if_gnt_r;
  assign if_rvalid = if_rvalid_r;
  assign if_rdata  = if_rdata_r;
  assign dm_gnt    = dm_gnt_r;
  assign dm_rvalid = dm_rvalid_r;
  assign dm_rdata  = dm_rdata_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mips32_mem_arbiter
//
// Self-checking bench for mips32_mem_arbiter. Scenarios (single or simultaneous
// requests, optional flush) are issued by a driver. The driver uses a
// transaction-level model to predict each grant and each completion and pushes
// them onto queues. A monitor on the falling edge pops and compares them
// whenever the DUT shows a gnt or rvalid. The memory array is modelled here
// with a combinational read and a write on the edge after mem_en.
// -----------------------------------------------------------------------------
module tb_mips32_mem_arbiter;

  localparam int LAT = 3;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [9:0]  if_addr = 10'd0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        flush = 1'b0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [9:0]  dm_addr = 10'd0;
  logic [31:0] dm_wdata = 32'd0;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        busy;

  mips32_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .flush(flush),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk1 = ~clk1;

  // Edge counter: after rising edge E has been processed, cyc == E
  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct { bit dm; bit we; logic [9:0] addr; logic [31:0] wd; int cyc; } gnt_t;
  typedef struct { bit dm; logic [31:0] data; int cyc; } rv_t;
  gnt_t gnt_q[$];
  rv_t  rv_q[$];

  // Reference state
  logic [31:0] ref_mem [1024];
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_dm_rdata;
  bit          last_w;   // 1 = DM won the last grant

  function automatic logic [31:0] init_word(input int a);
    if (a == 5) return 32'h0000ABCD;
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Memory array environment
  logic [31:0] mem_arr [1024];
  assign mem_rdata = mem_arr[mem_addr];
  initial begin
    for (int i = 0; i < 1024; i++) mem_arr[i] = init_word(i);
    forever begin
      @(posedge clk1);
      if (mem_en && mem_we) mem_arr[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every gnt/rvalid against the predicted queues
  always @(negedge clk1) begin
    gnt_t g;
    rv_t  r;
    if (rst_n) begin
      check("mem_en_with_gnt", 64'(mem_en), 64'(if_gnt | dm_gnt));
      if (if_gnt || dm_gnt) begin
        check("gnt_expected", 64'(gnt_q.size() != 0), 64'd1);
        if (gnt_q.size() != 0) begin
          g = gnt_q.pop_front();
          check("gnt_fields",
                64'({dm_gnt, if_gnt, mem_we, mem_addr, (g.dm ? mem_wdata : 32'd0), busy}),
                64'({g.dm, !g.dm, g.we, g.addr, (g.dm ? g.wd : 32'd0), 1'b1}));
          check("gnt_cycle", 64'(cyc), 64'(g.cyc));
        end
      end
      if (if_rvalid || dm_rvalid) begin
        check("rvalid_expected", 64'(rv_q.size() != 0), 64'd1);
        if (rv_q.size() != 0) begin
          r = rv_q.pop_front();
          check("rvalid_fields",
                64'({dm_rvalid, if_rvalid, (r.dm ? dm_rdata : if_rdata), busy}),
                64'({r.dm, !r.dm, r.data, 1'b0}));
          check("rvalid_cycle", 64'(cyc), 64'(r.cyc));
        end
      end
    end
  end

  task automatic push_if(input logic [9:0] a, input int g, input bit drop);
    gnt_q.push_back('{1'b0, 1'b0, a, 32'd0, g});
    last_w = 1'b0;
    if (!drop) begin
      exp_if_rdata = ref_mem[a];
      rv_q.push_back('{1'b0, exp_if_rdata, g + LAT});
    end
  endtask

  task automatic push_dm(input logic [9:0] a, input bit we, input logic [31:0] wd, input int g);
    gnt_q.push_back('{1'b1, we, a, wd, g});
    last_w = 1'b1;
    if (we) ref_mem[a] = wd;
    else    exp_dm_rdata = ref_mem[a];
    rv_q.push_back('{1'b1, exp_dm_rdata, g + LAT});
  endtask

  // One scenario: requests raised together, optional flush pulse.
  // fmode: 0 none, 1 during IF access (drops it), 2 during DM access, 3 while idle
  task automatic run_scenario(input bit want_if, input bit want_dm,
                              input logic [9:0] ia, input logic [9:0] da,
                              input bit dwe, input logic [31:0] dwd, input int fmode);
    int n, g_if, g_dm, fl;
    bit dm_first, drop;
    n = cyc + 1;
    fl = -1;
    drop = 1'b0;
    if (want_if && want_dm) begin
`ifdef ARB_RR_EN
      dm_first = (last_w == 1'b0);
`else
      dm_first = 1'b1;
`endif
    end else begin
      dm_first = want_dm;
    end
    g_if = n;
    g_dm = n;
    if (want_if && want_dm) begin
      if (dm_first) g_if = n + LAT + 1;
      else          g_dm = n + LAT + 1;
    end
    if (fmode == 1 && want_if && LAT >= 2) begin
      fl = g_if + int'($urandom_range(1, LAT - 1));
      drop = 1'b1;
    end else if (fmode == 2 && want_dm) begin
      fl = g_dm + int'($urandom_range(1, LAT));
    end else if (fmode == 3) begin
      fl = n + 2 * LAT + 2;
    end
    if (want_dm && dm_first)  push_dm(da, dwe, dwd, g_dm);
    if (want_if)              push_if(ia, g_if, drop);
    if (want_dm && !dm_first) push_dm(da, dwe, dwd, g_dm);

    if_addr  = ia;
    dm_addr  = da;
    dm_we    = dwe;
    dm_wdata = dwd;
    if_req   = want_if;
    dm_req   = want_dm;
    for (int s = 0; s < 2 * LAT + 4; s++) begin
      flush = (cyc + 1 == fl);
      @(posedge clk1); #1;
      if (if_gnt) if_req = 1'b0;
      if (dm_gnt) dm_req = 1'b0;
    end
    flush = 1'b0;
    check("req_served", 64'({if_req, dm_req}), 64'd0);
    if_req = 1'b0;
    dm_req = 1'b0;
    check("if_rdata_hold", 64'(if_rdata), 64'(exp_if_rdata));
    check("dm_rdata_hold", 64'(dm_rdata), 64'(exp_dm_rdata));
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  function automatic logic [9:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 10'd1023;
    if (r == 1) return 10'd0;
    return 10'($urandom_range(0, 15));
  endfunction

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin
    int kind;
    int gap;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    exp_if_rdata = 32'd0;
    exp_dm_rdata = 32'd0;
    last_w = 1'b1;

    // Reset with both requests asserted: every output stays low
    rst_n   = 1'b0;
    if_req  = 1'b1;
    dm_req  = 1'b1;
    if_addr = 10'd3;
    dm_addr = 10'd7;
    repeat (3) @(posedge clk1);
    #1;
    check("reset_outputs",
          64'({if_gnt, if_rvalid, |if_rdata, dm_gnt, dm_rvalid, |dm_rdata,
               mem_en, mem_we, mem_addr, |mem_wdata, busy}), 64'd0);
    rst_n = 1'b1;

    // Simultaneous IF read 3 / DM write 7, then DM reads 7 back
    run_scenario(1'b1, 1'b1, 10'd3, 10'd7, 1'b1, 32'hDEADBEEF, 0);
    run_scenario(1'b0, 1'b1, 10'd0, 10'd7, 1'b0, 32'd0, 0);
    // IF read of preloaded word 5
    run_scenario(1'b1, 1'b0, 10'd5, 10'd0, 1'b0, 32'd0, 0);
    // Ties back to back exercise the arbitration order
    run_scenario(1'b1, 1'b1, 10'd1, 10'd2, 1'b0, 32'd0, 0);
    run_scenario(1'b1, 1'b1, 10'd4, 10'd6, 1'b1, 32'h12345678, 0);
    // Flushed fetch, then an ordinary fetch
    run_scenario(1'b1, 1'b0, 10'd8, 10'd0, 1'b0, 32'd0, 1);
    run_scenario(1'b1, 1'b0, 10'd9, 10'd0, 1'b0, 32'd0, 0);
    // Flush during a DM write must not cancel it
    run_scenario(1'b0, 1'b1, 10'd0, 10'd11, 1'b1, 32'hCAFEF00D, 2);
    run_scenario(1'b0, 1'b1, 10'd0, 10'd11, 1'b0, 32'd0, 0);

    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 2));
      gap  = int'($urandom_range(0, 2));
      repeat (gap) begin
        @(posedge clk1); #1;
      end
      run_scenario(kind != 1, kind != 0, rand_addr(), rand_addr(),
                   1'($urandom_range(0, 1)), $urandom(), int'($urandom_range(0, 3)));
    end

    // Reset asserted in the middle of an IF access
    @(posedge clk1); #1;
    if_addr = 10'd9;
    if_req  = 1'b1;
    gnt_q.push_back('{1'b0, 1'b0, 10'd9, 32'd0, cyc + 1});
    @(posedge clk1); #1;
    if_req = 1'b0;
    @(posedge clk1); #1;
    rst_n = 1'b0;
    #1;
    check("reset_mid_access", 64'({mem_en, busy, if_gnt, if_rvalid, dm_gnt, dm_rvalid}), 64'd0);
    exp_if_rdata = 32'd0;
    exp_dm_rdata = 32'd0;
    last_w = 1'b1;
    repeat (2) @(posedge clk1);
    #1;
    rst_n = 1'b1;
    repeat (LAT + 3) @(posedge clk1);
    #1;
    check("if_rdata_after_reset", 64'(if_rdata), 64'd0);
    run_scenario(1'b1, 1'b1, 10'd5, 10'd7, 1'b0, 32'd0, 0);

    check("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
    check("rvalid_queue_drained", 64'(rv_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
